// File: rtl/host_if_pkg.sv
// Shared types and helpers for the host-side DMA endpoint.
// Holds the endpoint state encoding and the address-to-line-index mapping.
package host_if_pkg;

  typedef enum logic [2:0] {
    ST_INIT,
    ST_IDLE,
    ST_RD_WAIT,
    ST_RD_RESP,
    ST_WR_WAIT,
    ST_WR_READY
  } host_state_t;

  localparam int MAX_ADDR_BITS = 128;

  // Drops the in-line byte offset and keeps idx_bits of line index; upper bits alias.
  function automatic logic [MAX_ADDR_BITS-1:0] line_index(
    input logic [MAX_ADDR_BITS-1:0] addr,
    input int                       off_bits,
    input int                       idx_bits
  );
    logic [MAX_ADDR_BITS-1:0] mask;
    mask = ~({MAX_ADDR_BITS{1'b1}} << idx_bits);
    return (addr >> off_bits) & mask;
  endfunction

endpackage

// File: rtl/line_ram.sv
// Single-port line RAM: synchronous write, synchronous read into a held output register.
// One-cycle read latency; the output only changes when a read is enabled, never stalls.
module line_ram #(
  parameter int WIDTH = 512,
  parameter int DEPTH = 64,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic             re,
  input  logic [AW-1:0]    addr,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata
);

  // Array is never reset so contents survive an endpoint reset.
  logic [WIDTH-1:0] mem [DEPTH] = '{default: '0};

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)     rdata <= '0;
    else if (re) rdata <= mem[addr];
  end

endmodule

// File: rtl/host_mem_responder.sv
// Host DMA stand-in: init delay, fixed-latency line reads, line writes into a local RAM.
// Read data after RD_LATENCY edges, write window after WR_LATENCY; one request in flight, no queueing.
module host_mem_responder
  import host_if_pkg::*;
#(
  parameter int CL_SIZE_WIDTH = 512,
  parameter int ADDR_BITCOUNT = 64,
  parameter int DEPTH_LINES   = 64,
  parameter int INIT_DELAY    = 16,
  parameter int RD_LATENCY    = 4,
  parameter int WR_LATENCY    = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     host_rgo,
  input  logic                     host_wgo,
  input  logic                     host_re,
  input  logic                     host_we,
  input  logic [ADDR_BITCOUNT-1:0] address,
  input  logic [CL_SIZE_WIDTH-1:0] host_data_bus_write_in,
  output logic [CL_SIZE_WIDTH-1:0] host_data_bus_read_out,
  output logic                     host_init,
  output logic                     host_rd_ready,
  output logic                     host_wr_ready,
  output logic                     err
);

  localparam int          OFF_W     = $clog2(CL_SIZE_WIDTH / 8);
  localparam int          IDX_W     = $clog2(DEPTH_LINES);
  localparam logic [31:0] INIT_LAST = 32'(INIT_DELAY - 1);
  localparam logic [31:0] RD_LAST   = 32'(RD_LATENCY - 1);
  localparam logic [31:0] WR_LAST   = 32'(WR_LATENCY - 1);

  host_state_t              state;
  logic [31:0]              cnt;
  logic [31:0]              re_count;
  logic [IDX_W-1:0]         rd_idx;
  logic [IDX_W-1:0]         cur_idx;
  logic [MAX_ADDR_BITS-1:0] idx_full;
  logic                     ram_we;
  logic                     ram_re;
  logic [IDX_W-1:0]         ram_addr;
  logic                     unused_bits;

  assign idx_full = line_index(MAX_ADDR_BITS'(address), OFF_W, IDX_W);
  assign cur_idx  = idx_full[IDX_W-1:0];

  // Writes use the address presented with host_we; reads use the index latched at acceptance.
  assign ram_we   = (state == ST_WR_READY) && host_we;
  assign ram_re   = (state == ST_RD_WAIT) && (cnt == RD_LAST);
  assign ram_addr = (state == ST_WR_READY) ? cur_idx : rd_idx;

  assign unused_bits = &{1'b0, idx_full[MAX_ADDR_BITS-1:IDX_W], re_count};

  line_ram #(
    .WIDTH(CL_SIZE_WIDTH),
    .DEPTH(DEPTH_LINES)
  ) u_ram (
    .clk  (clk),
    .rst  (rst),
    .we   (ram_we),
    .re   (ram_re),
    .addr (ram_addr),
    .wdata(host_data_bus_write_in),
    .rdata(host_data_bus_read_out)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= ST_INIT;
      cnt           <= '0;
      re_count      <= '0;
      rd_idx        <= '0;
      host_init     <= 1'b0;
      host_rd_ready <= 1'b0;
      host_wr_ready <= 1'b0;
      err           <= 1'b0;
    end else begin
      if (host_re) re_count <= re_count + 32'd1;
      if (host_we && (state != ST_WR_READY)) err <= 1'b1;

      case (state)
        ST_INIT: begin
          if (cnt == INIT_LAST) begin
            cnt       <= '0;
            host_init <= 1'b1;
            state     <= ST_IDLE;
          end else begin
            cnt <= cnt + 32'd1;
          end
        end
        ST_IDLE: begin
          cnt <= '0;
          if (host_rgo && host_wgo) begin
            err <= 1'b1;
          end else if (host_rgo) begin
            rd_idx <= cur_idx;
            state  <= ST_RD_WAIT;
          end else if (host_wgo) begin
            state <= ST_WR_WAIT;
          end
        end
        ST_RD_WAIT: begin
          if (cnt == RD_LAST) begin
            cnt           <= '0;
            host_rd_ready <= 1'b1;
            state         <= ST_RD_RESP;
          end else begin
            cnt <= cnt + 32'd1;
          end
        end
        ST_RD_RESP: begin
          host_rd_ready <= 1'b0;
          state         <= ST_IDLE;
        end
        ST_WR_WAIT: begin
          if (cnt == WR_LAST) begin
            cnt           <= '0;
            host_wr_ready <= 1'b1;
            state         <= ST_WR_READY;
          end else begin
            cnt <= cnt + 32'd1;
          end
        end
        ST_WR_READY: begin
          if (host_we) begin
            host_wr_ready <= 1'b0;
            state         <= ST_IDLE;
          end else if (!host_wgo) begin
            err           <= 1'b1;
            host_wr_ready <= 1'b0;
            state         <= ST_IDLE;
          end
        end
        default: state <= ST_INIT;
      endcase
    end
  end

endmodule

// File: tb/tb_host_mem_responder.sv
// Directed bench for host_mem_responder: table of line writes/reads plus hand-written corner sequences.
module tb_host_mem_responder;

  logic         clk = 1'b0;
  logic         rst;
  logic         host_rgo, host_wgo, host_re, host_we;
  logic [63:0]  address;
  logic [511:0] wdat;
  logic [511:0] rdat;
  logic         host_init, host_rd_ready, host_wr_ready, err;

  int n_vec  = 0;
  int n_miss = 0;

  host_mem_responder dut (
    .clk                   (clk),
    .rst                   (rst),
    .host_rgo              (host_rgo),
    .host_wgo              (host_wgo),
    .host_re               (host_re),
    .host_we               (host_we),
    .address               (address),
    .host_data_bus_write_in(wdat),
    .host_data_bus_read_out(rdat),
    .host_init             (host_init),
    .host_rd_ready         (host_rd_ready),
    .host_wr_ready         (host_wr_ready),
    .err                   (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic         is_wr;
    logic [63:0]  addr;
    logic [511:0] data;
  } vec_t;

  vec_t vecs[11];

  localparam logic [511:0] PAT_A = {16{32'hA5A5_0001}};
  localparam logic [511:0] PAT_B = {16{32'h1234_5678}};
  localparam logic [511:0] PAT_C = {8{64'hDEAD_BEEF_0BAD_F00D}};
  localparam logic [511:0] PAT_D = {16{32'h0F0F_7777}};
  localparam logic [511:0] PAT_E = {16{32'hEEEE_EEEE}};

  task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic do_write(input logic [63:0] a, input logic [511:0] d);
    int k;
    host_wgo = 1'b1;
    address  = a;
    k = 0;
    while (k < 50) begin
      @(negedge clk);
      k++;
      if (host_wr_ready) break;
    end
    chk("wr_latency", 512'(k), 512'(3));
    host_we = 1'b1;
    wdat    = d;
    @(negedge clk);
    host_we  = 1'b0;
    host_wgo = 1'b0;
    chk("wr_ready_fall", 512'(host_wr_ready), 512'(0));
  endtask

  task automatic do_read(input logic [63:0] a, input logic [511:0] exp);
    int k;
    host_rgo = 1'b1;
    address  = a;
    k = 0;
    while (k < 50) begin
      @(negedge clk);
      k++;
      if (host_rd_ready) break;
    end
    chk("rd_latency", 512'(k), 512'(5));
    chk("rd_data", rdat, exp);
    host_rgo = 1'b0;
    host_re  = 1'b1;
    @(negedge clk);
    host_re = 1'b0;
    chk("rd_pulse_width", 512'(host_rd_ready), 512'(0));
  endtask

  initial begin
    int   k;
    logic bad;

    vecs[0]  = '{1'b1, 64'h40,   PAT_A};
    vecs[1]  = '{1'b0, 64'h40,   PAT_A};
    vecs[2]  = '{1'b0, 64'h1040, PAT_A};
    vecs[3]  = '{1'b1, 64'h80,   PAT_B};
    vecs[4]  = '{1'b0, 64'h80,   PAT_B};
    vecs[5]  = '{1'b0, 64'h9F,   PAT_B};
    vecs[6]  = '{1'b1, 64'hFFC0, PAT_C};
    vecs[7]  = '{1'b0, 64'h0FC0, PAT_C};
    vecs[8]  = '{1'b0, 64'h40,   PAT_A};
    vecs[9]  = '{1'b1, 64'h1040, PAT_D};
    vecs[10] = '{1'b0, 64'h40,   PAT_D};

    rst = 1'b1;
    host_rgo = 1'b0; host_wgo = 1'b0; host_re = 1'b0; host_we = 1'b0;
    address = '0; wdat = '0;

    // Reset values and init delay with requests held during INIT.
    @(negedge clk);
    @(negedge clk);
    chk("rst_init",     512'(host_init),     512'(0));
    chk("rst_rd_ready", 512'(host_rd_ready), 512'(0));
    chk("rst_wr_ready", 512'(host_wr_ready), 512'(0));
    chk("rst_err",      512'(err),           512'(0));
    chk("rst_rdata",    rdat,                512'(0));
    rst = 1'b0;
    host_rgo = 1'b1;
    host_wgo = 1'b1;
    bad = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      @(negedge clk);
      if (i == 15) begin
        chk("init_low_15", 512'(host_init), 512'(0));
        host_rgo = 1'b0;
        host_wgo = 1'b0;
      end
      if (host_rd_ready || host_wr_ready || err) bad = 1'b1;
    end
    chk("init_high_16", 512'(host_init), 512'(1));
    chk("init_quiet", 512'(bad), 512'(0));

    for (int i = 0; i < 11; i++) begin
      if (vecs[i].is_wr) do_write(vecs[i].addr, vecs[i].data);
      else               do_read(vecs[i].addr, vecs[i].data);
    end
    chk("err_after_table", 512'(err), 512'(0));

    // Simultaneous read and write request in IDLE.
    host_rgo = 1'b1; host_wgo = 1'b1; address = 64'h80; wdat = PAT_E;
    @(negedge clk);
    host_rgo = 1'b0; host_wgo = 1'b0;
    chk("both_err", 512'(err), 512'(1));
    bad = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (host_rd_ready || host_wr_ready) bad = 1'b1;
    end
    chk("both_no_ready", 512'(bad), 512'(0));
    do_read(64'h80, PAT_B);

    // Reset asserted in the middle of RD_WAIT.
    host_rgo = 1'b1; address = 64'h80;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst_rd_ready", 512'(host_rd_ready), 512'(0));
    chk("midrst_init",     512'(host_init),     512'(0));
    chk("midrst_err",      512'(err),           512'(0));
    chk("midrst_rdata",    rdat,                512'(0));
    host_rgo = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    bad = 1'b0;
    k = 0;
    while (k < 40) begin
      @(negedge clk);
      k++;
      if (host_rd_ready) bad = 1'b1;
      if (host_init) break;
    end
    chk("midrst_no_pulse", 512'(bad), 512'(0));
    chk("reinit_delay", 512'(k), 512'(16));
    do_read(64'h80, PAT_B);
    do_read(64'h40, PAT_D);

    // host_wgo dropped in WR_READY without a strobe.
    host_wgo = 1'b1; address = 64'h80; wdat = PAT_E;
    k = 0;
    while (k < 50) begin
      @(negedge clk);
      k++;
      if (host_wr_ready) break;
    end
    chk("drop_wr_latency", 512'(k), 512'(3));
    host_wgo = 1'b0;
    @(negedge clk);
    chk("drop_err", 512'(err), 512'(1));
    chk("drop_wr_ready", 512'(host_wr_ready), 512'(0));
    do_read(64'h80, PAT_B);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
